// File: rtl/matrix_pkg.sv
// Shared constants and types for the matrix engine scratch storage.
// Word/address widths and the readwrite command encoding live here.
package matrix_pkg;

    localparam int DATA_W = 256;
    localparam int ADDR_W = 4;
    localparam int DEPTH  = 2 ** ADDR_W;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] addr_t;

    localparam logic RW_WRITE = 1'b0;
    localparam logic RW_READ  = 1'b1;

endpackage : matrix_pkg

// File: rtl/ram_256x16.sv
// Single-port 16 x 256-bit scratch RAM with registered read data.
// Every word and the output register clear asynchronously on rst_n.
module ram_256x16
    import matrix_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    output logic [DATA_W-1:0] out,
    input  logic [DATA_W-1:0] in,
    input  logic [ADDR_W-1:0] address,
    input  logic              enable,
    input  logic              readwrite
);

    word_t mem_q [DEPTH];
    word_t mem_d [DEPTH];
    word_t out_q;
    word_t out_d;

    // readwrite is only looked at under enable, so X/Z on it while idle is harmless.
    always_comb begin
        mem_d = mem_q;
        out_d = out_q;
        if (enable) begin
            if (readwrite == RW_READ) begin
                out_d = mem_q[address];
            end else begin
                mem_d[address] = in;
            end
        end
    end

    // NOTE: the array is reset word by word because the block must come out of
    // reset all-zero; this is a flop array, not an SRAM macro.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            out_q <= '0;
        end else begin
            mem_q <= mem_d;
            out_q <= out_d;
        end
    end

    assign out = out_q;

endmodule : ram_256x16

// File: tb/tb_ram_256x16.sv
// Directed self-checking bench for ram_256x16.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_ram_256x16;
    import matrix_pkg::*;

    logic  clk = 1'b0;
    logic  rst_n;
    word_t dout;
    word_t din;
    addr_t address;
    logic  enable;
    logic  readwrite;

    int checks = 0;
    int errors = 0;

    ram_256x16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .out       (dout),
        .in        (din),
        .address   (address),
        .enable    (enable),
        .readwrite (readwrite)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input word_t obs, input word_t exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic wr(input addr_t a, input word_t d);
        enable    = 1'b1;
        readwrite = RW_WRITE;
        address   = a;
        din       = d;
        @(negedge clk);
        enable    = 1'b0;
    endtask

    task automatic rd(input addr_t a, input word_t exp, input string tag);
        enable    = 1'b1;
        readwrite = RW_READ;
        address   = a;
        @(negedge clk);
        enable    = 1'b0;
        check(tag, dout, exp);
    endtask

    task automatic idle(input int n, input logic rw, input addr_t a, input word_t d);
        for (int i = 0; i < n; i++) begin
            enable    = 1'b0;
            readwrite = rw;
            address   = a;
            din       = d;
            @(negedge clk);
        end
    endtask

    word_t ones;
    word_t half;

    initial begin
        ones      = '1;
        half      = {128'h0, {128{1'b1}}};
        rst_n     = 1'b0;
        enable    = 1'b0;
        readwrite = RW_READ;
        address   = '0;
        din       = '0;
        repeat (2) @(negedge clk);
        check("reset_out", dout, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // 1. Load a value, then assert reset mid-cycle.
        wr(4'd3, 256'hA5);
        rd(4'd3, 256'hA5, "pre_reset_read");
        #2 rst_n = 1'b0;
        #1 check("async_reset_out", dout, '0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            rd(addr_t'(a), '0, $sformatf("reset_mem_%0d", a));
        end

        // 2. Write / read back.
        wr(4'd0,  256'd0);
        wr(4'd1,  256'd1);
        wr(4'd10, 256'd2);
        wr(4'd11, 256'd3);
        wr(4'd4,  256'd4);
        rd(4'd0,  256'd0, "rb_0");
        rd(4'd1,  256'd1, "rb_1");
        rd(4'd10, 256'd2, "rb_10");
        rd(4'd11, 256'd3, "rb_11");
        rd(4'd4,  256'd4, "rb_4");

        // 3. Idle hold.
        rd(4'd0, 256'd0, "idle_pre");
        idle(1, RW_READ, 4'd1, '0);
        check("idle_hold_1", dout, 256'd0);
        idle(1, RW_READ, 4'd1, '0);
        check("idle_hold_2", dout, 256'd0);
        rd(4'd1, 256'd1, "idle_mem1");
        idle(2, RW_WRITE, 4'd11, ones);
        check("idle_write_hold", dout, 256'd1);
        idle(1, 1'bx, 4'd11, ones);
        check("idle_x_rw_hold", dout, 256'd1);
        rd(4'd11, 256'd3, "idle_no_write");

        // 4. A write does not disturb out.
        rd(4'd10, 256'd2, "wr_pre");
        wr(4'd10, ones);
        check("wr_no_through", dout, 256'd2);
        idle(1, RW_READ, 4'd10, '0);
        check("wr_hold", dout, 256'd2);
        rd(4'd10, ones, "wr_new_data");

        // 5. Full width and top address.
        wr(4'd14, 256'h1234);
        wr(4'd15, half);
        rd(4'd15, half, "full_width_15");
        rd(4'd14, 256'h1234, "neighbour_14");

        // 6. Reset during an enabled write.
        enable    = 1'b1;
        readwrite = RW_WRITE;
        address   = 4'd4;
        din       = 256'hDEAD;
        #2 rst_n  = 1'b0;
        #1 check("reset_mid_write_out", dout, '0);
        @(negedge clk);
        check("reset_held_out", dout, '0);
        enable = 1'b0;
        rst_n  = 1'b1;
        @(negedge clk);
        rd(4'd4,  '0, "write_discarded_4");
        rd(4'd15, '0, "cleared_15");
        rd(4'd10, '0, "cleared_10");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_ram_256x16
